copy_scheduler: RTL
===================

# copy_scheduler

- Shares one `copy_engine` word-copy datapath between `NUM_REQ` requesters.
- Arbitrates requests round-robin, latches the winner's descriptor (source, destination, length) and drives the engine's `start`.
- Waits for the engine's `done`, then returns a completion pulse to the owning requester.
- Sits between client DMA ports and the single `copy_engine` instance.

## Interface
- `NUM_REQ`, 4: number of requester channels (2..8).
- `TIMEOUT_CYCLES`, 65535: watchdog limit in cycles; used only with `COPY_SCHED_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  per-channel request; held with fields stable until accepted.
- `req_src_addr`  in  NUM_REQ*32  channel i at bits [32i+31:32i].
- `req_dst_addr`  in  NUM_REQ*32  same packing.
- `req_length`  in  NUM_REQ*16  length in words, same packing.
- `req_ready`  out  NUM_REQ  one-hot accept strobe; combinational.
- `cpl_valid`  out  NUM_REQ  one-cycle completion pulse, one-hot.
- `cpl_err`  out  1  qualifies `cpl_valid`; 1 = timed out.
- `eng_start`  out  1  start pulse to the engine.
- `eng_src_addr`, `eng_dst_addr`  out  32 each  latched descriptor addresses.
- `eng_length`  out  16  latched descriptor length.
- `eng_done`  in  1  engine completion pulse.
- `eng_rst`  out  1  one-cycle engine reset on timeout.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  owner of the current transfer.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CPL.
- IDLE:
  - If any `req_valid` is set, the arbiter picks a winner.
  - `req_ready[winner]`=1 that cycle.
  - Descriptor and `grant_id` are latched at the edge.
  - Next state is ISSUE, or CPL if latched length == 0.
- Zero-length requests never start the engine; they complete with `cpl_err`=0.
- Round-robin: search starts at `last_grant+1` modulo `NUM_REQ`. `last_grant` updates on each accept.
- ISSUE: `eng_start`=1 for exactly one cycle; `eng_*` fields are stable. Next state is WAIT.
- WAIT:
  - Any cycle with `eng_done`=1 goes to CPL with `cpl_err`=0.
  - `eng_done` is ignored outside WAIT.
- CPL:
  - `cpl_valid[grant_id]`=1 for one cycle. Next state is IDLE.
  - `req_ready` stays 0 in CPL, so there is one idle cycle between transfers.
- `eng_*` outputs hold their last values until the next accept.
- Reset value of every output is 0: `req_ready`, `cpl_valid`, `cpl_err`, `eng_*`, `eng_rst`, `busy`, `grant_id`.
- After reset, `last_grant`=`NUM_REQ-1`, so channel 0 wins first.
- Reset mid-transfer: the FSM goes to IDLE and the in-flight transfer is dropped with no completion. The engine is reset by the system reset.
- A requester that drops `req_valid` before it is accepted is simply skipped.
- A request re-asserted in the same cycle as its own `cpl_valid` is eligible in the next IDLE cycle.

## Timing
- Accept at edge T; `eng_start` high in T+1; WAIT from T+2.
- `eng_done` seen in cycle D leads to `cpl_valid` in D+1 and IDLE in D+2.
- Zero length: accept at T, `cpl_valid` in T+1.
- Back-to-back throughput overhead: 3 scheduler cycles per transfer in addition to engine time.
- `req_ready` is combinational from state, `req_valid` and the arbiter pointer. All other outputs are registered.

## Configuration
- `COPY_SCHED_TIMEOUT_EN` defined:
  - A 16-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `eng_done`, the next state is CPL with `cpl_err`=1, and `eng_rst` pulses for one cycle coincident with `cpl_valid`.
  - If `eng_done` arrives in the same cycle as the limit, `eng_done` wins and `cpl_err`=0.
- Not defined: no counter is built, WAIT waits indefinitely, and `eng_rst` and `cpl_err` are tied 0.

## Structure
- Package `copy_sched_pkg`:
  - state enum `sched_state_t` {IDLE, ISSUE, WAIT, CPL};
  - `ADDR_W`=32, `LEN_W`=16;
  - `TIMEOUT_W`=16.
- Sub-module `copy_sched_rr_arbiter`:
  - inputs: `req` vector, `last_grant`, `enable`;
  - outputs: one-hot grant and its encoded index;
  - purely combinational, with the pointer register held in the parent.

## Test plan
- After reset, `req_valid`=4'b0101, lengths 8 and 3 → ch0 accepted first. Then:
  - `eng_start` pulse with length 8;
  - `eng_done` → `cpl_valid`=4'b0001;
  - ch2 accepted next with length 3.
- All four channels held valid over 8 transfers → grant order 0,1,2,3,0,1,2,3; exactly one `eng_start` per accept.
- ch1 with length 0 → `req_ready[1]` at T, `cpl_valid[1]` at T+1, `eng_start` never asserted.
- `rst` asserted in WAIT, then ch3 requests → no `cpl_valid` for the old owner; all outputs 0 during reset; ch0 priority restored.
- `eng_done` pulsed while IDLE, then a normal transfer → stray pulse ignored, transfer completes only on its own `eng_done`.
- With `COPY_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, `eng_done` held 0 → `cpl_valid` with `cpl_err`=1 and `eng_rst` pulse. A rerun with `eng_done` exactly at the limit → `cpl_err`=0.

Source files
------------

// File: rtl/copy_sched_pkg.sv
// ============================================================================
// Module   : copy_sched_pkg
// Purpose  : Shared types and widths for the copy scheduler block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package copy_sched_pkg;

  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CPL   = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/copy_sched_rr_arbiter.sv
// ============================================================================
// Module   : copy_sched_rr_arbiter
// Purpose  : Combinational round-robin pick, searching from last_grant+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module copy_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (enable && !w_found && req[w_pos]) begin
        w_found      = 1'b1;
        grant[w_pos] = 1'b1;
        grant_idx    = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/copy_scheduler.sv
// ============================================================================
// Module   : copy_scheduler
// Purpose  : Round-robin sharing of one copy_engine among NUM_REQ requesters.
//            Optional watchdog: define COPY_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module copy_scheduler
  import copy_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_src_addr,
  input  logic [NUM_REQ*32-1:0]      req_dst_addr,
  input  logic [NUM_REQ*16-1:0]      req_length,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         cpl_valid,
  output logic                       cpl_err,
  output logic                       eng_start,
  output logic [31:0]                eng_src_addr,
  output logic [31:0]                eng_dst_addr,
  output logic [15:0]                eng_length,
  input  logic                       eng_done,
  output logic                       eng_rst,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t       r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_id;
  logic [NUM_REQ-1:0] r_owner_oh;
  logic [NUM_REQ-1:0] r_cpl_valid;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [LEN_W-1:0]   r_len;
  logic               r_eng_start;
  logic               r_cpl_err;
  logic               r_eng_rst;
  logic               r_busy;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_src;
  logic [ADDR_W-1:0]  w_sel_dst;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_timeout;

  // Gating with rst keeps req_ready low while reset is held.
  assign w_arb_en = (r_state == IDLE) && !rst;

  copy_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  assign w_any     = |w_grant;
  assign w_sel_src = req_src_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_dst = req_dst_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_len = req_length[w_grant_idx*LEN_W +: LEN_W];

`ifdef COPY_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state == ISSUE) begin
      r_timer <= '0;
    end else if (r_state == WAIT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_state == WAIT) && (r_timer == TIMEOUT_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_owner_oh   <= '0;
      r_cpl_valid  <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_eng_start  <= 1'b0;
      r_cpl_err    <= 1'b0;
      r_eng_rst    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      r_cpl_valid <= '0;
      r_cpl_err   <= 1'b0;
      r_eng_rst   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last_grant <= w_grant_idx;
            r_grant_id   <= w_grant_idx;
            r_owner_oh   <= w_grant;
            r_src        <= w_sel_src;
            r_dst        <= w_sel_dst;
            r_len        <= w_sel_len;
            r_busy       <= 1'b1;
            if (w_sel_len == '0) begin
              r_state     <= CPL;
              r_cpl_valid <= w_grant;
            end else begin
              r_state     <= ISSUE;
              r_eng_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // A done pulse on the limit cycle takes priority over the watchdog.
          if (eng_done) begin
            r_state     <= CPL;
            r_cpl_valid <= r_owner_oh;
          end else if (w_timeout) begin
            r_state     <= CPL;
            r_cpl_valid <= r_owner_oh;
            r_cpl_err   <= 1'b1;
            r_eng_rst   <= 1'b1;
          end
        end
        CPL: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = w_grant;
  assign cpl_valid    = r_cpl_valid;
  assign cpl_err      = r_cpl_err;
  assign eng_start    = r_eng_start;
  assign eng_src_addr = r_src;
  assign eng_dst_addr = r_dst;
  assign eng_length   = r_len;
  assign eng_rst      = r_eng_rst;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;

endmodule

`default_nettype wire
